// File: rtl/pad_input_conditioner.sv
// Conditions asynchronous pad bits: per-bit synchronizer, consecutive-sample debounce,
// registered stable level and single-cycle rise/fall event pulses.
module pad_input_conditioner #(
  parameter int unsigned      WIDTH         = 8,
  parameter int unsigned      SYNC_STAGES   = 2,
  parameter int unsigned      FILTER_CYCLES = 4,
  parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] pad_y_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] level_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic             event_o
);

  localparam int unsigned     CntW   = $clog2(FILTER_CYCLES) + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_chain_q, sync_chain_d;
  logic [WIDTH-1:0][CntW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]                  level_q, level_d;
  logic [WIDTH-1:0]                  rise_q, rise_d;
  logic [WIDTH-1:0]                  fall_q, fall_d;
  logic                              event_q, event_d;
  logic [WIDTH-1:0]                  sync_s;

  // Plain shift chain, no logic between stages; runs regardless of en_i.
  always_comb begin
    sync_chain_d[0] = pad_y_i;
    for (int s = 1; s < int'(SYNC_STAGES); s++) begin
      sync_chain_d[s] = sync_chain_q[s-1];
    end
  end

  assign sync_s = sync_chain_q[SYNC_STAGES-1];

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (!en_i || (sync_s[i] == level_q[i])) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntMax) begin
        level_d[i] = sync_s[i];
        cnt_d[i]   = '0;
        rise_d[i]  = sync_s[i];
        fall_d[i]  = ~sync_s[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CntW'(1);
      end
    end
    event_d = |(rise_d | fall_d);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_chain_q <= {SYNC_STAGES{RESET_VAL}};
      cnt_q        <= '0;
      level_q      <= RESET_VAL;
      rise_q       <= '0;
      fall_q       <= '0;
      event_q      <= 1'b0;
    end else begin
      sync_chain_q <= sync_chain_d;
      cnt_q        <= cnt_d;
      level_q      <= level_d;
      rise_q       <= rise_d;
      fall_q       <= fall_d;
      event_q      <= event_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign event_o = event_q;

endmodule

// File: doc/pad_input_conditioner.md
Name: pad_input_conditioner

Overview:
- Sits directly downstream of the chip's input pad buses and consumes the asynchronous pad-side `y` bits before any core logic uses them.
- For each bit it provides:
  - a multi-flop synchronizer into the core clock domain;
  - a per-bit consecutive-sample glitch filter (debounce);
  - a registered stable level output;
  - single-cycle rise and fall event pulses.
- One instance per input bus; all core logic uses its outputs, never raw pad bits.

Parameters:
- WIDTH, 8, number of pad bits conditioned.
- SYNC_STAGES, 2, synchronizer flop depth per bit; legal range 2..4.
- FILTER_CYCLES, 4, consecutive differing synchronized samples required before the filtered level flips; legal range 1..255; 1 means no filtering.
- RESET_VAL, {WIDTH{1'b0}}, value loaded into level_o and all sync flops on reset.

Ports:
- clk_i, input, 1, core clock.
- reset_i, input, 1, reset; synchronous, active-high.
- pad_y_i, input, WIDTH, asynchronous bits from the input pad bus.
- en_i, input, 1, filter enable; synchronous to clk_i.
- level_o, output, WIDTH, debounced, synchronized level per bit (registered).
- rise_o, output, WIDTH, one-cycle pulse, bit's level_o went 0->1 this cycle (registered).
- fall_o, output, WIDTH, one-cycle pulse, bit's level_o went 1->0 this cycle (registered).
- event_o, output, 1, OR-reduction of rise_o|fall_o (registered).

Behaviour:
- Interface rules (fixed):
  - Single clock domain clk_i.
  - Reset is synchronous and active-high on reset_i.
  - pad_y_i is the only asynchronous input.
- Reset: at a rising edge with reset_i=1:
  - sync flops <= RESET_VAL;
  - level_o <= RESET_VAL;
  - all filter counters <= 0;
  - rise_o, fall_o, event_o <= 0.
  - Reset mid-filter discards partial counts.
  - No pulses are generated by the reset load itself, nor on the first cycle after reset.
- Synchronizer:
  - Per-bit shift chain of SYNC_STAGES flops; sync_q = last stage.
  - The chain runs regardless of en_i. No logic between stages.
- Filter counter: one per bit, width clog2(FILTER_CYCLES)+1. On each non-reset edge with en_i=1:
  - sync_q == level_o: counter <= 0.
  - sync_q != level_o and counter == FILTER_CYCLES-1: level_o <= sync_q, counter <= 0.
  - sync_q != level_o otherwise: counter <= counter+1.
- Consequences of the counter rules:
  - Any sample equal to level_o restarts the count. Glitches shorter than FILTER_CYCLES synchronized samples never reach level_o.
  - The counter never exceeds FILTER_CYCLES-1, so there is no wrap-around.
- Latency:
  - Pad step first sampled at edge N (counted as edge 1), held stable, en_i=1 throughout.
  - level_o changes at edge N+SYNC_STAGES+FILTER_CYCLES-1.
  - This is SYNC_STAGES+FILTER_CYCLES edges total (2+4 = 6 at defaults).
- Pulses:
  - rise_o[i]/fall_o[i] are asserted on the same edge that updates level_o[i].
  - They are high for exactly one cycle and never both high for the same bit.
  - event_o is registered on the same edge, from the next-state pulses.
  - Multiple bits may pulse in the same cycle.
- en_i=0:
  - Counters are forced to 0 and level_o holds.
  - rise_o/fall_o/event_o are 0 at the next edge.
  - The sync chain keeps updating.
- Re-enable: after en_i returns to 1, a difference must persist for a fresh FILTER_CYCLES samples before level_o changes.
- Simultaneous events:
  - Bits are fully independent; per-bit counters never interact.
  - reset_i has priority over en_i and all filter updates.
- FILTER_CYCLES=1: level_o follows sync_q with one extra register stage; every sync_q toggle produces a pulse.

Test Plan:
- Reset load: assert reset_i for 3 cycles with pad_y_i=8'hFF. Required:
  - level_o=8'h00, rise_o=fall_o=0, event_o=0 during reset;
  - first rise_o=8'hFF at the 6th edge after the first post-reset edge.
- Clean step: from level 8'h00, drive pad_y_i[3]=1 before edge N. Required:
  - level_o[3]=1 and rise_o=8'h08, event_o=1 after edge N+5;
  - rise_o back to 0 after edge N+6;
  - other bits unchanged.
- Glitch rejection: pad_y_i[0] high for exactly 3 cycles, then low. Required:
  - level_o[0] stays 0, no pulses;
  - repeat with 4 cycles -> rise_o[0] pulse followed, after the low returns, by fall_o[0] pulse.
- Chatter restart: pad_y_i[5] pattern 1,1,1,0,1,1,1,1 per cycle. Required:
  - exactly one rise_o[5], occurring 4 synchronized samples after the final 0 sample;
  - never earlier.
- Enable gating: en_i=0 while pad_y_i=8'hF0 for 20 cycles. Required:
  - level_o holds 8'h00, no pulses;
  - set en_i=1 -> rise_o=8'hF0 exactly 4 edges later.
- Reset mid-filter: pad_y_i[7] goes high, and reset_i is asserted for 1 cycle after 3 filter counts. Required:
  - level_o[7]=0 after reset;
  - rise_o[7] appears only after a full 6-edge latency measured from the first post-reset sample.
